// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes, opcode/funct
// values and datapath mux/ALU selects.
package multicycle_ctrl_pkg;

    typedef logic [4:0] state_t;

    localparam state_t S_RESET    = 5'd0;
    localparam state_t S_FETCH    = 5'd1;
    localparam state_t S_FETCH_WB = 5'd2;
    localparam state_t S_DECODE   = 5'd3;
    localparam state_t S_EXEC_R   = 5'd4;
    localparam state_t S_WB_R     = 5'd5;
    localparam state_t S_EXEC_I   = 5'd6;
    localparam state_t S_WB_I     = 5'd7;
    localparam state_t S_ADDR     = 5'd8;
    localparam state_t S_MEM_RD   = 5'd9;
    localparam state_t S_WB_LW    = 5'd10;
    localparam state_t S_MEM_WR   = 5'd11;
    localparam state_t S_BRANCH   = 5'd12;
    localparam state_t S_JUMP     = 5'd13;
    localparam state_t S_ILLEGAL  = 5'd14;
    localparam state_t S_EXC_EPC  = 5'd15;
    localparam state_t S_EXC_RD   = 5'd16;
    localparam state_t S_EXC_JMP  = 5'd17;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] SRCA_PC = 2'd0;
    localparam logic [1:0] SRCA_A  = 2'd1;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_MDR    = 3'd3;

    localparam logic [2:0] MADDR_PC     = 3'b000;
    localparam logic [2:0] MADDR_ALUOUT = 3'b001;
    localparam logic [2:0] MADDR_EXC    = 3'b010;

    localparam logic [1:0] RWM_RT = 2'b00;
    localparam logic [1:0] RWM_RD = 2'b01;
    localparam logic [1:0] RWM_SP = 2'b10;
    localparam logic [1:0] RWM_RA = 2'b11;

    localparam logic [3:0] WDC_ALUOUT = 4'b0000;
    localparam logic [3:0] WDC_MDR    = 4'b0001;
    localparam logic [3:0] WDC_SP     = 4'b1010;

    localparam logic [7:0] SP_INIT    = 8'd227;
    localparam logic [7:0] EXC_VECTOR = 8'd255;

    function automatic logic is_rtype_fn(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Per-state cycle counter: clears whenever the FSM enters a new state and flags the
// last cycle of a MEM_WAIT-long memory access.
module mem_wait_timer
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == CNT_W'(MEM_WAIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath. Define MULTICYCLE_CTRL_EXC_EN to
// trap overflow and illegal opcodes through EPC and the exception vector.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       O,
    input  logic       LT,
    input  logic       GT,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    output logic       PCWrite,
    output logic       PCWriteCond_taken,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       ALUOut_w,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] RegWriteMUX,
    output logic [2:0] MuxAddr,
    output logic [2:0] ALUControl,
    output logic [2:0] PCSrc,
    output logic [3:0] WriteDataCtrl,
    output logic       rst_out
);

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             wait_done;
    logic             br_taken;
    logic             ovf;

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .load  (state_d != state_q),
        .cnt   (cnt),
        .done  (wait_done)
    );

    assign br_taken = ((OPCODE == OP_BEQ) && !LT && !GT) ||
                      ((OPCODE == OP_BNE) && (LT || GT));

`ifdef MULTICYCLE_CTRL_EXC_EN
    // AND cannot overflow, so a stale O flag must not trap it.
    assign ovf = O && !((state_q == S_EXEC_R) && (FUNCT == FN_AND));
`else
    logic unused_o;
    assign unused_o = O;
    assign ovf      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    if (wait_done) state_d = S_FETCH_WB;
            S_FETCH_WB: state_d = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:      state_d = is_rtype_fn(FUNCT) ? S_EXEC_R : S_ILLEGAL;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = ovf ? S_EXC_EPC : S_WB_R;
            S_EXEC_I:   state_d = ovf ? S_EXC_EPC : S_WB_I;
            // Effective address is held a second cycle before the access starts.
            S_ADDR:     if (cnt != '0) state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (wait_done) state_d = S_WB_LW;
`ifdef MULTICYCLE_CTRL_EXC_EN
            S_ILLEGAL:  state_d = S_EXC_EPC;
            S_EXC_EPC:  state_d = S_EXC_RD;
            S_EXC_RD:   if (wait_done) state_d = S_EXC_JMP;
            S_EXC_JMP:  state_d = S_FETCH;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        PCWrite           = 1'b0;
        PCWriteCond_taken = 1'b0;
        MemWrite          = 1'b0;
        MemRead           = 1'b0;
        IRWrite           = 1'b0;
        ALUOut_w          = 1'b0;
        RegWrite          = 1'b0;
        EPCWrite          = 1'b0;
        ALUSrcA           = SRCA_PC;
        ALUSrcB           = SRCB_B;
        RegWriteMUX       = RWM_RD;
        MuxAddr           = MADDR_PC;
        ALUControl        = ALU_PASS;
        PCSrc             = PCSRC_ALU;
        WriteDataCtrl     = WDC_ALUOUT;
        case (state_q)
            S_RESET: begin
                RegWrite = 1'b1; RegWriteMUX = RWM_SP; WriteDataCtrl = WDC_SP;
            end
            S_FETCH: begin
                MemRead = 1'b1; ALUSrcB = SRCB_FOUR; ALUControl = ALU_ADD;
            end
            S_FETCH_WB: begin
                PCWrite = 1'b1; IRWrite = 1'b1; ALUSrcB = SRCB_FOUR; ALUControl = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH; ALUControl = ALU_ADD; ALUOut_w = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_A; ALUOut_w = 1'b1;
                case (FUNCT)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            S_WB_R:  RegWrite = 1'b1;
            S_EXEC_I, S_ADDR: begin
                ALUSrcA = SRCA_A; ALUSrcB = SRCB_IMM; ALUControl = ALU_ADD; ALUOut_w = 1'b1;
            end
            S_WB_I: begin
                RegWrite = 1'b1; RegWriteMUX = RWM_RT;
            end
            S_MEM_RD: begin
                MemRead = 1'b1; MuxAddr = MADDR_ALUOUT;
            end
            S_WB_LW: begin
                RegWrite = 1'b1; RegWriteMUX = RWM_RT; WriteDataCtrl = WDC_MDR;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1; MuxAddr = MADDR_ALUOUT;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_A; ALUControl = ALU_SUB; PCSrc = PCSRC_ALUOUT;
                PCWrite = br_taken; PCWriteCond_taken = br_taken;
            end
            S_JUMP: begin
                PCWrite = 1'b1; PCSrc = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_CTRL_EXC_EN
            S_EXC_EPC: begin
                EPCWrite = 1'b1; ALUSrcB = SRCB_FOUR; ALUControl = ALU_SUB;
            end
            S_EXC_RD: begin
                MemRead = 1'b1; MuxAddr = MADDR_EXC;
            end
            S_EXC_JMP: begin
                PCWrite = 1'b1; PCSrc = PCSRC_MDR;
            end
`endif
            default: ;
        endcase
        // Asserted reset kills every enable at once, aborting any write in flight.
        if (!reset) begin
            PCWrite = 1'b0; PCWriteCond_taken = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
            IRWrite = 1'b0; ALUOut_w = 1'b0; RegWrite = 1'b0; EPCWrite = 1'b0;
            ALUSrcA = '0; ALUSrcB = '0; RegWriteMUX = '0; MuxAddr = '0;
            ALUControl = '0; PCSrc = '0; WriteDataCtrl = '0;
        end
    end

    assign rst_out = !reset || (state_q == S_RESET);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back for R-type ADD/SUB/AND, ADDI, LW, SW, BEQ, BNE and J. It sits between the instruction register (OPCODE/FUNCT) and the datapath muxes, register file, ALU and memory. Memory latency is a parameter rather than a hard-coded stall. An optional exception path handles overflow and illegal opcodes.

## Interface
- MEM_WAIT, 3: memory read latency in cycles; legal range 1..15.
- CNT_W, $clog2(MEM_WAIT+1): wait-counter width; derived, never overridden.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- O, LT, GT  in  1 each  ALU overflow, less-than and greater-than flags; equal = !LT && !GT.
- OPCODE, FUNCT  in  6 each  IR fields, stable from DECODE onward.
- PCWrite, PCWriteCond_taken, MemWrite, MemRead, IRWrite, ALUOut_w, RegWrite, EPCWrite  out  1 each  write enables.
- ALUSrcA  out  2  0 = PC, 1 = A.
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- RegWriteMUX  out  2  00 = rt, 01 = rd, 10 = $29, 11 = $31.
- MuxAddr  out  3  000 = PC, 001 = ALUOut, 010 = exception vector 255.
- ALUControl  out  3  000 = pass A, 001 = add, 010 = sub, 011 = and.
- PCSrc  out  3  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = zero-extended MDR byte.
- WriteDataCtrl  out  4  0000 = ALUOut, 0001 = MDR, 1010 = SP init constant 227.
- rst_out  out  1  high while reset is asserted and during the RESET state.

## Operation
- Outputs are decoded combinationally from the state register and wait counter. Any output not listed for a state is 0, except RegWriteMUX, which is 01.
- RESET, 1 cycle: RegWrite=1, RegWriteMUX=10, WriteDataCtrl=1010, rst_out=1. Then FETCH.
- FETCH, MEM_WAIT cycles: MemRead=1, MuxAddr=000, ALUSrcA=0, ALUSrcB=1, ALUControl=001. Counter counts 0..MEM_WAIT-1. Then FETCH_WB.
- FETCH_WB: PCWrite=1, PCSrc=0, IRWrite=1, ALUSrcB=1, ALUControl=001. Then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUControl=001, ALUOut_w=1 (branch target). Dispatch from this state:
  - opcode 0x00 with funct 0x20/0x22/0x24 → EXEC_R.
  - 0x08 → EXEC_I.
  - 0x23/0x2B → ADDR.
  - 0x04/0x05 → BRANCH.
  - 0x02 → JUMP.
  - anything else → ILLEGAL.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUControl add/sub/and per funct, ALUOut_w=1. Then WB_R: RegWrite=1, RegWriteMUX=01, WriteDataCtrl=0000.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, add, ALUOut_w=1. Then WB_I: RegWrite=1, RegWriteMUX=00.
- ADDR: ALUSrcA=1, ALUSrcB=2, add, ALUOut_w=1. LW → MEM_RD; SW → MEM_WR.
- MEM_RD, MEM_WAIT cycles: MemRead=1, MuxAddr=001. Then WB_LW: RegWrite=1, RegWriteMUX=00, WriteDataCtrl=0001.
- MEM_WR, 1 cycle: MemWrite=1, MuxAddr=001.
- BRANCH: ALUSrcA=1, ALUSrcB=0, sub, PCSrc=1. PCWrite=1 iff (BEQ && equal) || (BNE && !equal). PCWriteCond_taken mirrors PCWrite.
- JUMP: PCWrite=1, PCSrc=2.
- WB_R, WB_I, WB_LW, MEM_WR, BRANCH and JUMP each return to FETCH.
- O is sampled only at the end of EXEC_R and EXEC_I, and only for add/sub/addi. It is ignored for AND.

## Timing
- Instruction latency, clk edges from FETCH entry back to FETCH entry:
  - R-type / ADDI: MEM_WAIT+4.
  - LW: 2·MEM_WAIT+5.
  - SW: MEM_WAIT+5.
  - BEQ/BNE/J: MEM_WAIT+3.
- Reset assertion forces state=RESET, counter=0, all outputs 0 and rst_out=1 asynchronously, from any state. A write in progress is aborted by MemWrite/RegWrite dropping immediately.
- Reset release: the first clk edge executes RESET; FETCH begins on the next edge.
- The wait counter clears on every state entry. With MEM_WAIT=1, FETCH and MEM_RD last exactly one cycle.

## Configuration
- MULTICYCLE_CTRL_EXC_EN defined:
  - Overflow at EXEC_R/EXEC_I goes to EXC_EPC instead of write-back, and ILLEGAL goes to EXC_EPC.
  - EXC_EPC, 1 cycle: EPCWrite=1, ALUSrcA=0, ALUSrcB=1, sub (PC−4).
  - EXC_RD, MEM_WAIT cycles: MemRead=1, MuxAddr=010.
  - EXC_JMP: PCWrite=1, PCSrc=3, then FETCH.
- Undefined:
  - EPCWrite is tied to 0.
  - O is ignored and overflowed results are written back.
  - ILLEGAL is a single-cycle NOP returning to FETCH.

## Structure
- multicycle_ctrl_pkg holds: state enum; opcode/funct constants; ALUControl, ALUSrcB, PCSrc, MuxAddr, RegWriteMUX and WriteDataCtrl encodings; SP init value 227; exception vector 255.
- One sub-module, mem_wait_timer: loads on state entry, asserts done on its final cycle, CNT_W wide.

## Test plan
- Reset low mid-MEM_WR (MemWrite=1) → MemWrite=0 and rst_out=1 with no clk edge. After release: one cycle with RegWrite=1, RegWriteMUX=10, WriteDataCtrl=1010, then FETCH.
- MEM_WAIT=3, ADD (op 0x00, funct 0x20), O=0 → MemRead high 3 cycles, IRWrite/PCWrite on cycle 4, WB_R RegWrite with RegWriteMUX=01 on cycle 7.
- MEM_WAIT=1, LW → MEM_RD lasts 1 cycle; WB_LW WriteDataCtrl=0001 on cycle 7.
- BEQ with LT=GT=0 → PCWrite=1, PCSrc=1. BNE with LT=0, GT=0 → PCWrite=0, then FETCH.
- EXC_EN, ADDI with O=1 → no RegWrite; EPCWrite for 1 cycle, MuxAddr=010 for MEM_WAIT cycles, PCWrite with PCSrc=3. Without EXC_EN: WB_I RegWrite=1.
- Opcode 0x3F → EXC sequence with EXC_EN; one-cycle NOP back to FETCH without it.
